// File: rtl/io_seq_pkg.sv
// Shared definitions for the IO sequencer: FSM state encoding and default widths.
package io_seq_pkg;

    typedef enum logic [1:0] {
        RUN,
        WAIT_PRESS,
        COMMIT,
        HALTED
    } seq_state_t;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned SW_W_DEF   = 18;

endpackage

// File: rtl/io_sequencer_debouncer.sv
// Insert button conditioning: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle press pulse on its rising edge.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press,
    output logic level
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            count   <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            // Flip only after DEBOUNCE_CYCLES consecutive mismatching samples.
            if (sync2 != level) begin
                if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= ~level;
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/io_sequencer.sv
// Sequences the single-cycle datapath around input, output and halt
// instructions by gating PC load and register/memory write enables.
module io_sequencer
    import io_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned SW_W            = SW_W_DEF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              insert,
    input  logic [SW_W-1:0]   SW,
    input  logic              input_flag,
    input  logic              output_flag,
    input  logic              halt,
    input  logic [DATA_W-1:0] out_data,
    output logic              pc_enable,
    output logic              commit_enable,
    output logic [DATA_W-1:0] user_input,
    output logic [DATA_W-1:0] display_value,
    output logic              display_valid,
    output logic              waiting_input,
    output logic              halted
);

    seq_state_t state;
    seq_state_t state_next;
    logic       press;
    logic       level;
    logic       take_output;

    input_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk  (CLK),
        .reset(reset),
        .raw  (insert),
        .press(press),
        .level(level)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_enable     = 1'b0;
        commit_enable = 1'b0;
        waiting_input = 1'b0;
        halted        = 1'b0;
        take_output   = 1'b0;
        case (state)
            RUN: begin
                pc_enable     = ~(halt | input_flag);
                commit_enable = ~(halt | input_flag);
                if (halt) begin
                    state_next = HALTED;
                end else if (input_flag) begin
                    state_next = WAIT_PRESS;
                end else if (output_flag) begin
                    take_output = 1'b1;
                end
            end
            WAIT_PRESS: begin
                waiting_input = 1'b1;
                if (press) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                pc_enable     = 1'b1;
                commit_enable = 1'b1;
                state_next    = RUN;
            end
            HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            user_input    <= '0;
            display_value <= '0;
            display_valid <= 1'b0;
        end else begin
            if (state == WAIT_PRESS && press) begin
                user_input <= DATA_W'(SW);
            end
            if (take_output) begin
                display_value <= out_data;
                display_valid <= 1'b1;
            end
        end
    end

    logic unused_level;
    assign unused_level = level;

endmodule
